// File: rtl/neural_stream_scheduler.sv
// Round-robin burst scheduler sharing one compressor among N_CH streams; first beat CFG_CYCLES+1 cycles after grant.
// Data path is combinational in XFER; c_tready back-pressure goes straight to the granted channel's s_tready.
module neural_stream_scheduler #(
  parameter int N_CH         = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LEN    = 16,
  parameter int CFG_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 8,
  localparam int CW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_CH-1:0]            s_tvalid,
  input  logic [N_CH-1:0]            s_tlast,
  output logic [N_CH-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]      c_tdata,
  output logic                       c_tvalid,
  output logic                       c_tlast,
  input  logic                       c_tready,
  input  logic [N_CH*DATA_WIDTH-1:0] chan_threshold,
  input  logic                       sched_enable,
  output logic [DATA_WIDTH-1:0]      cfg_threshold,
  output logic                       cfg_enable,
  output logic [CW-1:0]              cur_chan,
  output logic                       burst_done
);

  localparam int BW      = $clog2(BURST_LEN + 1);
  localparam int DRAIN_N = (DRAIN_CYCLES == 0) ? 1 : DRAIN_CYCLES;
  localparam int CNT_MAX = (CFG_CYCLES > DRAIN_N) ? CFG_CYCLES : DRAIN_N;
  localparam int TW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_XFER, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]           cur_chan_q, cur_chan_d;
  logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [DATA_WIDTH-1:0]   cfg_thr_q, cfg_thr_d;
  logic                    burst_done_q, burst_done_d;

  logic [DATA_WIDTH-1:0]   ch_dat [N_CH];
  logic [DATA_WIDTH-1:0]   ch_thr [N_CH];
  logic                    grant_vld;
  logic [CW-1:0]           grant_idx;
  logic [CW-1:0]           next_ptr;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign ch_dat[g] = s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign ch_thr[g] = chan_threshold[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First requesting channel at or after rr_ptr, wrapping modulo N_CH.
  always_comb begin
    logic [CW:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = {1'b0, rr_ptr_q} + (CW+1)'(i);
      if (cand >= (CW+1)'(N_CH)) cand = cand - (CW+1)'(N_CH);
      if (!grant_vld && s_tvalid[cand[CW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[CW-1:0];
      end
    end
  end

  assign next_ptr = (cur_chan_q == CW'(N_CH - 1)) ? '0 : cur_chan_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cur_chan_d   = cur_chan_q;
    beat_cnt_d   = beat_cnt_q;
    tmr_d        = tmr_q;
    cfg_thr_d    = cfg_thr_q;
    burst_done_d = 1'b0;
    s_tready     = '0;
    c_tdata      = '0;
    c_tvalid     = 1'b0;
    c_tlast      = 1'b0;
    cfg_enable   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sched_enable && grant_vld) begin
          cur_chan_d = grant_idx;
          cfg_thr_d  = ch_thr[grant_idx];
          tmr_d      = '0;
          state_d    = S_CFG;
        end
      end
      S_CFG: begin
        if (tmr_q == TW'(CFG_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_XFER;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_XFER: begin
        cfg_enable           = 1'b1;
        c_tvalid             = s_tvalid[cur_chan_q];
        c_tdata              = ch_dat[cur_chan_q];
        s_tready[cur_chan_q] = c_tready;
        c_tlast = c_tvalid & (s_tlast[cur_chan_q] | (beat_cnt_q == BW'(BURST_LEN - 1)));
        if (c_tvalid && c_tready) begin
          if (c_tlast) begin
            burst_done_d = 1'b1;
            rr_ptr_d     = next_ptr;
            beat_cnt_d   = '0;
            tmr_d        = '0;
            state_d      = S_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        cfg_enable = 1'b1;
        if (tmr_q == TW'(DRAIN_N - 1)) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rst_n is active-high in this codebase despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      cur_chan_q   <= '0;
      beat_cnt_q   <= '0;
      tmr_q        <= '0;
      cfg_thr_q    <= '0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cur_chan_q   <= cur_chan_d;
      beat_cnt_q   <= beat_cnt_d;
      tmr_q        <= tmr_d;
      cfg_thr_q    <= cfg_thr_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign cur_chan      = cur_chan_q;
  assign cfg_threshold = cfg_thr_q;
  assign burst_done    = burst_done_q;

endmodule

// File: tb/tb_neural_stream_scheduler.sv
// Scoreboard bench: per-channel expected sample queues plus a round-robin burst model checked by an
// independent monitor on every compressor-side beat.
module tb_neural_stream_scheduler;
  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int BL   = 16;
  localparam int CFG  = 2;
  localparam int DRN  = 8;
  localparam int CW   = 2;
  localparam int GAP  = 1 + DRN + 1 + CFG;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } item_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_CH*DW-1:0]   s_tdata;
  logic [N_CH-1:0]      s_tvalid;
  logic [N_CH-1:0]      s_tlast;
  logic [N_CH-1:0]      s_tready;
  logic [DW-1:0]        c_tdata;
  logic                 c_tvalid;
  logic                 c_tlast;
  logic                 c_tready;
  logic [N_CH*DW-1:0]   chan_threshold;
  logic                 sched_enable;
  logic [DW-1:0]        cfg_threshold;
  logic                 cfg_enable;
  logic [CW-1:0]        cur_chan;
  logic                 burst_done;

  always #5 clk = ~clk;

  neural_stream_scheduler #(
    .N_CH(N_CH), .DATA_WIDTH(DW), .BURST_LEN(BL), .CFG_CYCLES(CFG), .DRAIN_CYCLES(DRN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .c_tdata(c_tdata), .c_tvalid(c_tvalid), .c_tlast(c_tlast), .c_tready(c_tready),
    .chan_threshold(chan_threshold), .sched_enable(sched_enable),
    .cfg_threshold(cfg_threshold), .cfg_enable(cfg_enable),
    .cur_chan(cur_chan), .burst_done(burst_done)
  );

  int checks = 0;
  int errors = 0;
  item_t src_q [N_CH][$];
  item_t exp_q [N_CH][$];
  logic [DW-1:0] thr_m [N_CH];
  int cyc = 0;
  int rdy_mode = 0;
  bit have_prev = 0;
  int last_end_cyc = 0;
  bit lat_chk = 0;
  int lat_cyc = 0;
  int bcnt = 0;
  int rr = 0;
  int nbursts = 0;
  int burst_log[$];
  bit done_exp = 0;
  int lowrun = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic [DW-1:0] d, input logic l);
    item_t it;
    it.data = d;
    it.last = l;
    src_q[k].push_back(it);
    exp_q[k].push_back(it);
  endtask

  task automatic set_thr(input int k, input logic [DW-1:0] v);
    thr_m[k] = v;
    chan_threshold[k*DW +: DW] = v;
  endtask

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < N_CH; k++) n += exp_q[k].size();
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_quiet();
    int t = 0;
    while (t < 4000 && pending() != 0) begin
      step();
      t++;
    end
    if (pending() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_quiet: timeout with %0d samples still expected", pending());
    end
    repeat (GAP + 2) step();
  endtask

  task automatic new_phase();
    have_prev = 0;
    nbursts   = 0;
    burst_log.delete();
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
  endtask

  // Source driver: presents each channel's queue head, retires it after an accepted handshake.
  initial begin
    logic [N_CH-1:0] fire;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    c_tready = 1'b0;
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int k = 0; k < N_CH; k++) begin
        if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          s_tvalid[k]          = 1'b1;
          s_tdata[k*DW +: DW]  = src_q[k][0].data;
          s_tlast[k]           = src_q[k][0].last;
        end else begin
          s_tvalid[k]          = 1'b0;
          s_tdata[k*DW +: DW]  = '0;
          s_tlast[k]           = 1'b0;
        end
      end
      c_tready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: round-robin/burst model, compared on every compressor beat.
  initial begin
    int k;
    int exp_k;
    int c;
    item_t it;
    bit exp_last;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bcnt = 0; rr = 0; done_exp = 0; lowrun = 0; have_prev = 0;
      end else begin
        chk("burst_done", burst_done, done_exp);
        done_exp = 0;
        if (!cfg_enable) begin
          lowrun++;
        end else begin
          if (lowrun > 0 && have_prev && rdy_mode == 0) chk("cfg_low_cycles", lowrun, CFG + 1);
          lowrun = 0;
        end
        if (c_tvalid && c_tready) begin
          k = int'(cur_chan);
          if (bcnt == 0) begin
            exp_k = -1;
            for (int j = 0; j < N_CH; j++) begin
              c = (rr + j) % N_CH;
              if (exp_k < 0 && exp_q[c].size() > 0) exp_k = c;
            end
            chk("grant_chan", 64'(k), 64'(exp_k));
            if (have_prev && rdy_mode == 0) chk("burst_gap", cyc - last_end_cyc, GAP);
            if (lat_chk) begin
              chk("first_beat_latency", cyc, lat_cyc);
              lat_chk = 0;
            end
            burst_log.push_back(k);
            nbursts++;
          end
          chk("cfg_threshold", cfg_threshold, thr_m[k]);
          chk("cfg_enable_xfer", cfg_enable, 1'b1);
          chk("s_tready_others", s_tready & ~(N_CH'(1) << k), '0);
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL data: unexpected beat 0x%0h on ch%0d, expected none", c_tdata, k);
            exp_last = c_tlast;
          end else begin
            it = exp_q[k].pop_front();
            chk("c_tdata", c_tdata, it.data);
            exp_last = it.last || (bcnt == BL - 1);
            chk("c_tlast", c_tlast, exp_last);
          end
          if (exp_last) begin
            bcnt = 0;
            rr = (k + 1) % N_CH;
            done_exp = 1;
            last_end_cyc = cyc;
            have_prev = 1;
          end else begin
            bcnt++;
          end
        end
      end
    end
  end

  initial begin
    int t;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    rst_n          = 1'b1;
    sched_enable   = 1'b0;
    chan_threshold = '0;
    for (int k = 0; k < N_CH; k++) set_thr(k, $urandom);
    repeat (3) step();
    chk("rst_s_tready", s_tready, '0);
    chk("rst_c_tvalid", c_tvalid, 1'b0);
    chk("rst_c_tlast", c_tlast, 1'b0);
    chk("rst_c_tdata", c_tdata, '0);
    chk("rst_cfg_enable", cfg_enable, 1'b0);
    chk("rst_cfg_threshold", cfg_threshold, '0);
    chk("rst_burst_done", burst_done, 1'b0);
    chk("rst_cur_chan", cur_chan, '0);
    rst_n = 1'b0;
    sched_enable = 1'b1;
    repeat (20) step();
    chk("idle_no_request", {cfg_enable, c_tvalid}, '0);

    // Lone requester: 40 beats split into 16/16/8, re-granted after each drain.
    new_phase();
    lat_cyc = cyc + CFG + 2;
    lat_chk = 1;
    for (int i = 1; i <= 40; i++) push(2, DW'(32'h2000 + i), i == 40);
    wait_quiet();
    chk("t1_burst_count", nbursts, 3);
    chk("t1_all_ch2", (burst_log[0] == 2) && (burst_log[1] == 2) && (burst_log[2] == 2), 1);

    // All channels continuously valid.
    do_reset();
    new_phase();
    for (int k = 0; k < N_CH; k++)
      for (int i = 0; i < 32; i++) push(k, DW'((k << 16) | i), 1'b0);
    wait_quiet();
    chk("t2_burst_count", nbursts, 8);
    for (int i = 0; i < 5; i++) chk("t2_grant_order", burst_log[i], exp_order[i]);

    // Short record on ch1 followed by ch2.
    new_phase();
    for (int i = 1; i <= 5; i++) push(1, DW'(32'h1100 + i), i == 5);
    for (int i = 1; i <= 10; i++) push(2, DW'(32'h2200 + i), i == 10);
    wait_quiet();
    chk("t3_burst_count", nbursts, 2);
    chk("t3_order", (burst_log[0] == 1) && (burst_log[1] == 2), 1);

    // Per-channel thresholds.
    new_phase();
    set_thr(0, 32'h100); set_thr(1, 32'h200); set_thr(2, 32'h300); set_thr(3, 32'h400);
    for (int i = 1; i <= 20; i++) begin
      push(0, DW'(32'h0A00 + i), (i == 20) || ($urandom_range(0, 7) == 0));
      push(3, DW'(32'h3A00 + i), (i == 20) || ($urandom_range(0, 7) == 0));
    end
    wait_quiet();

    // Grants blocked while disabled, then resume.
    new_phase();
    sched_enable = 1'b0;
    for (int i = 1; i <= 3; i++) push(1, DW'(32'h1D00 + i), i == 3);
    repeat (20) step();
    chk("disabled_cfg_enable", cfg_enable, 1'b0);
    chk("disabled_s_tready", s_tready, '0);
    chk("disabled_pending", exp_q[1].size(), 3);
    sched_enable = 1'b1;
    wait_quiet();

    // Random back-pressure, all channels.
    new_phase();
    rdy_mode = 1;
    for (int k = 0; k < N_CH; k++)
      for (int i = 0; i < 30; i++) push(k, DW'((k << 16) | i), (i == 29) || ($urandom_range(0, 9) == 0));
    wait_quiet();
    rdy_mode = 0;
    repeat (2) step();

    // Reset in the middle of a ch0 burst.
    do_reset();
    new_phase();
    for (int i = 1; i <= 30; i++) push(0, DW'(32'hC000 + i), i == 30);
    t = 0;
    while (bcnt != 7 && t < 200) begin
      step();
      t++;
    end
    chk("t6_reached_beat7", bcnt, 7);
    rst_n = 1'b1;
    #1;
    chk("t6_rst_c_tvalid", c_tvalid, 1'b0);
    chk("t6_rst_c_tlast", c_tlast, 1'b0);
    chk("t6_rst_s_tready", s_tready, '0);
    chk("t6_rst_cfg_enable", cfg_enable, 1'b0);
    chk("t6_rst_cur_chan", cur_chan, '0);
    chk("t6_rst_cfg_threshold", cfg_threshold, '0);
    chk("t6_pending", exp_q[0].size(), 23);
    step();
    step();
    rst_n = 1'b0;
    new_phase();
    wait_quiet();
    chk("t6_burst_count", nbursts, 2);
    chk("t6_first_grant", burst_log[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "timeout");
  end

endmodule
